// File: rtl/dphy_interleave_checker_pkg.sv
// dphy_interleave_checker_pkg: FSM encodings shared by the interleave checker and its bench
package dphy_interleave_checker_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/dphy_interleave_checker_fifo.sv
// dphy_interleave_checker_fifo: per-channel sync FIFO with flush; a pop frees a slot for a same-cycle push
module dphy_interleave_checker_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 128
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;
   assign empty_o = cnt_q == '0;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = mem_q[rd_q];
   always_ff @(posedge clk_i) begin
      if (!rst_n_i || flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end
endmodule

// File: rtl/dphy_interleave_checker.sv
// dphy_interleave_checker: buffers per-channel input lines and checks the merged output interleaves them
// round-robin, byte-exact, starting from a selectable channel
module dphy_interleave_checker
   import dphy_interleave_checker_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int BUS_W      = 4,
   parameter int LINE_WORDS = 50,
   parameter int LONG_EVEN  = 0,
   parameter int FIFO_DEPTH = 128,
   parameter int CNT_W      = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        start_i,
   input  logic [$clog2(NUM_CH)-1:0]   first_ch_i,
   input  logic [NUM_CH-1:0]           in_valid_i,
   input  logic [NUM_CH*BUS_W*8-1:0]   in_data_i,
   input  logic [NUM_CH-1:0]           in_end_i,
   input  logic                        out_valid_i,
   input  logic [BUS_W*8-1:0]          out_data_i,
   input  logic                        test_end_i,
   output logic                        mismatch_o,
   output logic [CNT_W-1:0]            err_cnt_o,
   output logic [CNT_W-1:0]            tot_in_o,
   output logic [CNT_W-1:0]            tot_out_o,
   output logic [$clog2(NUM_CH)-1:0]   cur_ch_o,
   output logic [NUM_CH-1:0]           ovf_o,
   output logic                        udf_o,
   output logic                        done_o,
   output logic                        pass_o
);
   localparam int CH_W = $clog2(NUM_CH);
   localparam int DW   = BUS_W * 8;
   localparam int WC_W = $clog2(2 * LINE_WORDS + 1);
   localparam int NB_W = $clog2(BUS_W + 1);
   logic [1:0]        state_q, state_d;
   logic [CH_W-1:0]   cur_ch_q, cur_ch_d, first_ch_q, first_ch_d, next_ch;
   logic [WC_W-1:0]   word_ctr_q, word_ctr_d, wc_inc, line_len;
   logic              odd_even_q, odd_even_d, udf_q, udf_d, mismatch_q, mismatch_d, pass_q, pass_d;
   logic [CNT_W-1:0]  err_q, err_d, tin_q, tin_d, tout_q, tout_d, in_bytes;
   logic [NUM_CH-1:0] ovf_q, ovf_d, ovf_set, fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [DW-1:0]     fifo_dout [NUM_CH];
   logic [DW-1:0]     exp_word;
   logic [NB_W-1:0]   nbad, bad;
   logic [CNT_W:0]    err_sum;
   logic              active, cur_empty, wrap, unused_ok;
   assign unused_ok = ^in_end_i;
   assign active    = state_q == ST_CHECK && !start_i;
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign fifo_push[g] = active && in_valid_i[g];
      assign fifo_pop[g]  = active && out_valid_i && cur_ch_q == CH_W'(g);
      assign ovf_set[g]   = fifo_push[g] && fifo_full[g] && !fifo_pop[g];
      dphy_interleave_checker_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .flush_i (start_i),
         .push_i  (fifo_push[g]),
         .pop_i   (fifo_pop[g]),
         .din_i   (in_data_i[g*DW +: DW]),
         .dout_o  (fifo_dout[g]),
         .full_o  (fifo_full[g]),
         .empty_o (fifo_empty[g])
      );
   end
   assign exp_word  = fifo_dout[cur_ch_q];
   assign cur_empty = fifo_empty[cur_ch_q];
   // 4-state inequality so an X byte on the output bus is scored as bad in simulation
   always_comb begin
      nbad     = '0;
      in_bytes = '0;
      for (int b = 0; b < BUS_W; b++) nbad = nbad + NB_W'(out_data_i[b*8 +: 8] !== exp_word[b*8 +: 8]);
      for (int c = 0; c < NUM_CH; c++) in_bytes = in_bytes + (in_valid_i[c] ? CNT_W'(BUS_W) : '0);
   end
   assign bad      = cur_empty ? NB_W'(BUS_W) : nbad;
   assign err_sum  = {1'b0, err_q} + (CNT_W+1)'(bad);
   assign wc_inc   = word_ctr_q + 1'b1;
   assign line_len = (LONG_EVEN != 0 && odd_even_q) ? WC_W'(2 * LINE_WORDS) : WC_W'(LINE_WORDS);
   assign wrap     = wc_inc == line_len;
   assign next_ch  = cur_ch_q == CH_W'(NUM_CH - 1) ? '0 : cur_ch_q + 1'b1;
   always_comb begin
      state_d    = state_q;
      cur_ch_d   = cur_ch_q;
      first_ch_d = first_ch_q;
      word_ctr_d = word_ctr_q;
      odd_even_d = odd_even_q;
      err_d      = err_q;
      tin_d      = tin_q;
      tout_d     = tout_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      pass_d     = pass_q;
      mismatch_d = 1'b0;
      if (start_i) begin
         state_d    = ST_CHECK;
         cur_ch_d   = first_ch_i;
         first_ch_d = first_ch_i;
         word_ctr_d = '0;
         odd_even_d = 1'b0;
         err_d      = '0;
         tin_d      = '0;
         tout_d     = '0;
         ovf_d      = '0;
         udf_d      = 1'b0;
         pass_d     = 1'b0;
      end else if (state_q == ST_CHECK) begin
         tin_d = tin_q + in_bytes;
         ovf_d = ovf_q | ovf_set;
         if (out_valid_i) begin
            err_d      = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
            tout_d     = tout_q + CNT_W'(BUS_W);
            udf_d      = udf_q | cur_empty;
            mismatch_d = bad != '0;
            word_ctr_d = wrap ? '0 : wc_inc;
            if (wrap) begin
               cur_ch_d   = next_ch;
               odd_even_d = odd_even_q ^ (LONG_EVEN != 0 && next_ch == first_ch_q);
            end
         end
         if (test_end_i) begin
            state_d = ST_DONE;
            pass_d  = tin_d == tout_d && err_d == '0 && ovf_d == '0 && !udf_d;
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         cur_ch_q   <= '0;
         first_ch_q <= '0;
         word_ctr_q <= '0;
         odd_even_q <= 1'b0;
         err_q      <= '0;
         tin_q      <= '0;
         tout_q     <= '0;
         ovf_q      <= '0;
         udf_q      <= 1'b0;
         mismatch_q <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_ch_q   <= cur_ch_d;
         first_ch_q <= first_ch_d;
         word_ctr_q <= word_ctr_d;
         odd_even_q <= odd_even_d;
         err_q      <= err_d;
         tin_q      <= tin_d;
         tout_q     <= tout_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         mismatch_q <= mismatch_d;
         pass_q     <= pass_d;
      end
   end
   assign mismatch_o = mismatch_q;
   assign err_cnt_o  = err_q;
   assign tot_in_o   = tin_q;
   assign tot_out_o  = tout_q;
   assign cur_ch_o   = cur_ch_q;
   assign ovf_o      = ovf_q;
   assign udf_o      = udf_q;
   assign done_o     = state_q == ST_DONE;
   assign pass_o     = pass_q;
endmodule

// File: tb/tb_dphy_interleave_checker.sv
// tb_dphy_interleave_checker: scoreboard bench for the interleave checker (4 ch, 4-byte bus, short lines)
module tb_dphy_interleave_checker;
   logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, test_end = 1'b0, out_valid = 1'b0;
   logic [1:0]   first_ch = '0;
   logic [3:0]   in_valid = '0, in_end = '0;
   logic [127:0] in_data = '0;
   logic [31:0]  out_data = '0;
   logic         mismatch_o, udf_o, done_o, pass_o;
   logic [7:0]   err_cnt_o, tot_in_o, tot_out_o;
   logic [1:0]   cur_ch_o;
   logic [3:0]   ovf_o;
   logic [31:0]  m_q [4][$];
   bit           exp_mm [$];
   int           m_cur, m_first, m_wc, m_oe, m_err, m_tin, m_tout;
   logic [3:0]   m_ovf;
   bit           m_udf, m_act;
   int           errors = 0, checks = 0;

   dphy_interleave_checker #(
      .NUM_CH(4), .BUS_W(4), .LINE_WORDS(4), .LONG_EVEN(1), .FIFO_DEPTH(8), .CNT_W(8)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .first_ch_i(first_ch),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_end_i(in_end),
      .out_valid_i(out_valid), .out_data_i(out_data), .test_end_i(test_end),
      .mismatch_o(mismatch_o), .err_cnt_o(err_cnt_o), .tot_in_o(tot_in_o), .tot_out_o(tot_out_o),
      .cur_ch_o(cur_ch_o), .ovf_o(ovf_o), .udf_o(udf_o), .done_o(done_o), .pass_o(pass_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] wd(input int c, input int n);
      return {8'(c + 1), 8'(n), 8'(n * 7 + 3), 8'(32'hA0 | c)};
   endfunction

   task automatic model_clear(input int first, input bit act);
      for (int c = 0; c < 4; c++) m_q[c].delete();
      exp_mm.delete();
      m_cur = first; m_first = first; m_wc = 0; m_oe = 0;
      m_err = 0; m_tin = 0; m_tout = 0; m_ovf = '0; m_udf = 0; m_act = act;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 0; test_end = 0; in_valid = '0; out_valid = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear(0, 0);
   endtask

   task automatic do_start(input int first);
      start = 1'b1; first_ch = 2'(first);
      @(posedge clk); #1;
      start = 1'b0;
      model_clear(first, 1);
   endtask

   task automatic do_end();
      test_end = 1'b1;
      @(posedge clk); #1;
      test_end = 1'b0;
      m_act = 0;
   endtask

   // drives one cycle and advances the reference model; pops are modelled before pushes
   task automatic cycle(input logic [3:0] iv, input logic [127:0] id, input logic ov, input logic [31:0] od);
      int nb;
      logic [31:0] e;
      in_valid = iv; in_data = id; out_valid = ov; out_data = od;
      nb = 0;
      if (m_act && ov) begin
         if (m_q[m_cur].size() == 0) begin
            nb = 4; m_udf = 1;
         end else begin
            e = m_q[m_cur].pop_front();
            for (int b = 0; b < 4; b++) if (od[b*8 +: 8] !== e[b*8 +: 8]) nb++;
         end
         m_err = (m_err + nb > 255) ? 255 : m_err + nb;
         m_tout += 4;
         m_wc++;
         if (m_wc == (m_oe != 0 ? 8 : 4)) begin
            m_wc = 0;
            m_cur = (m_cur + 1) % 4;
            if (m_cur == m_first) m_oe ^= 1;
         end
      end
      if (m_act) for (int c = 0; c < 4; c++) if (iv[c]) begin
         m_tin += 4;
         if (m_q[c].size() < 8) m_q[c].push_back(id[c*32 +: 32]);
         else m_ovf[c] = 1'b1;
      end
      exp_mm.push_back(nb != 0);
      @(posedge clk); #1;
      in_valid = '0; out_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_cnt_o); end
      checks++; if (tot_in_o !== 8'd0 || tot_out_o !== 8'd0) begin errors++; $display("FAIL reset_tot got=%0d/%0d exp=0/0", tot_in_o, tot_out_o); end
      checks++; if (cur_ch_o !== 2'd0) begin errors++; $display("FAIL reset_cur got=%0d exp=0", cur_ch_o); end
      checks++; if (ovf_o !== 4'd0 || udf_o !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b/%b exp=0000/0", ovf_o, udf_o); end
      checks++; if (done_o !== 1'b0 || pass_o !== 1'b0 || mismatch_o !== 1'b0) begin errors++; $display("FAIL reset_status got=%b%b%b exp=000", done_o, pass_o, mismatch_o); end
   endtask

   task automatic run_lines(input int first, input int bad_ch, input int bad_word);
      logic [127:0] id;
      logic [31:0]  od;
      bit mm;
      int pulses, ch;
      do_start(first);
      pulses = 0;
      checks++; if (cur_ch_o !== 2'(first) || tot_in_o !== 8'd0) begin errors++; $display("FAIL start_state cur=%0d tin=%0d exp=%0d/0", cur_ch_o, tot_in_o, first); end
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 4; c++) id[c*32 +: 32] = wd(c, i);
         cycle(4'hF, id, 1'b0, '0);
         mm = exp_mm.pop_front();
         checks++; if (mismatch_o !== mm) begin errors++; $display("FAIL push_mm got=%b exp=%b", mismatch_o, mm); end
      end
      for (int k = 0; k < 4; k++) begin
         ch = (first + k) % 4;
         for (int i = 0; i < 4; i++) begin
            checks++; if (cur_ch_o !== 2'(ch)) begin errors++; $display("FAIL rr_cur line=%0d word=%0d got=%0d exp=%0d", k, i, cur_ch_o, ch); end
            od = wd(ch, i);
            if (ch == bad_ch && i == bad_word) od ^= 32'h0000_FF00;
            cycle('0, '0, 1'b1, od);
            mm = exp_mm.pop_front();
            checks++; if (mismatch_o !== mm) begin errors++; $display("FAIL rr_mm ch=%0d word=%0d got=%b exp=%b", ch, i, mismatch_o, mm); end
            if (mismatch_o === 1'b1) pulses++;
         end
      end
      do_end();
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL rr_done got=%b exp=1", done_o); end
      checks++; if (pass_o !== (bad_ch < 0)) begin errors++; $display("FAIL rr_pass got=%b exp=%b", pass_o, bad_ch < 0); end
      checks++; if (err_cnt_o !== (bad_ch < 0 ? 8'd0 : 8'd1)) begin errors++; $display("FAIL rr_err got=%0d exp=%0d", err_cnt_o, bad_ch < 0 ? 0 : 1); end
      checks++; if (tot_in_o !== 8'd64 || tot_out_o !== 8'd64) begin errors++; $display("FAIL rr_tot got=%0d/%0d exp=64/64", tot_in_o, tot_out_o); end
      checks++; if (pulses != (bad_ch < 0 ? 0 : 1)) begin errors++; $display("FAIL rr_pulses got=%0d exp=%0d", pulses, bad_ch < 0 ? 0 : 1); end
   endtask

   task automatic test_round_robin();
      run_lines(2, -1, 0);
   endtask

   task automatic test_corrupt();
      run_lines(2, 3, 1);
   endtask

   task automatic test_long_even();
      logic [127:0] id;
      bit mm;
      int ch, len;
      do_start(0);
      for (int k = 0; k < 9; k++) begin
         ch = k % 4;
         len = ((k / 4) % 2) != 0 ? 8 : 4;
         checks++; if (cur_ch_o !== 2'(ch)) begin errors++; $display("FAIL le_cur line=%0d got=%0d exp=%0d", k, cur_ch_o, ch); end
         for (int j = 0; j <= len; j++) begin
            id = '0;
            if (j < len) id[ch*32 +: 32] = wd(ch, j + k * 8);
            cycle(j < len ? 4'(1 << ch) : 4'd0, id, j > 0, j > 0 ? wd(ch, j - 1 + k * 8) : '0);
            mm = exp_mm.pop_front();
            checks++; if (mismatch_o !== mm) begin errors++; $display("FAIL le_mm line=%0d j=%0d got=%b exp=%b", k, j, mismatch_o, mm); end
         end
      end
      checks++; if (cur_ch_o !== 2'd1 || err_cnt_o !== 8'd0) begin errors++; $display("FAIL le_final cur=%0d err=%0d exp=1/0", cur_ch_o, err_cnt_o); end
   endtask

   task automatic test_underflow();
      bit mm;
      do_start(1);
      cycle('0, '0, 1'b1, 32'hDEAD_BEEF);
      mm = exp_mm.pop_front();
      checks++; if (mismatch_o !== 1'b1 || mm !== 1'b1) begin errors++; $display("FAIL udf_mm got=%b exp=1", mismatch_o); end
      checks++; if (udf_o !== 1'b1) begin errors++; $display("FAIL udf_flag got=%b exp=1", udf_o); end
      checks++; if (err_cnt_o !== 8'd4 || tot_out_o !== 8'd4 || tot_in_o !== 8'd0) begin errors++; $display("FAIL udf_cnt err=%0d tout=%0d tin=%0d exp=4/4/0", err_cnt_o, tot_out_o, tot_in_o); end
   endtask

   task automatic test_overflow();
      logic [127:0] id;
      do_start(0);
      for (int i = 0; i < 9; i++) begin
         id = '0; id[63:32] = wd(1, i);
         cycle(4'b0010, id, 1'b0, '0);
         void'(exp_mm.pop_front());
      end
      checks++; if (ovf_o !== 4'b0010) begin errors++; $display("FAIL ovf_flag got=%b exp=0010", ovf_o); end
      checks++; if (tot_in_o !== 8'd36) begin errors++; $display("FAIL ovf_tin got=%0d exp=36", tot_in_o); end
      do_end();
      checks++; if (done_o !== 1'b1 || pass_o !== 1'b0) begin errors++; $display("FAIL ovf_pass done=%b pass=%b exp=1/0", done_o, pass_o); end
   endtask

   task automatic test_full_push_pop();
      logic [127:0] id;
      bit mm;
      do_start(1);
      for (int i = 0; i < 8; i++) begin
         id = '0; id[63:32] = wd(1, i);
         cycle(4'b0010, id, 1'b0, '0);
         void'(exp_mm.pop_front());
      end
      id = '0; id[63:32] = wd(1, 8);
      cycle(4'b0010, id, 1'b1, wd(1, 0));
      mm = exp_mm.pop_front();
      checks++; if (mismatch_o !== mm || ovf_o !== 4'd0) begin errors++; $display("FAIL fpp_flags mm=%b ovf=%b exp=%b/0000", mismatch_o, ovf_o, mm); end
      for (int i = 1; i < 4; i++) begin
         cycle('0, '0, 1'b1, wd(1, i));
         mm = exp_mm.pop_front();
         checks++; if (mismatch_o !== mm) begin errors++; $display("FAIL fpp_mm word=%0d got=%b exp=%b", i, mismatch_o, mm); end
      end
      checks++; if (cur_ch_o !== 2'(m_cur) || cur_ch_o !== 2'd2) begin errors++; $display("FAIL fpp_cur got=%0d exp=2", cur_ch_o); end
      checks++; if (tot_in_o !== 8'd36 || tot_out_o !== 8'd16 || err_cnt_o !== 8'd0) begin errors++; $display("FAIL fpp_cnt tin=%0d tout=%0d err=%0d exp=36/16/0", tot_in_o, tot_out_o, err_cnt_o); end
   endtask

   task automatic test_saturate();
      bit mm;
      do_start(0);
      for (int i = 0; i < 70; i++) begin
         cycle('0, '0, 1'b1, 32'h1234_5678);
         mm = exp_mm.pop_front();
         checks++; if (mismatch_o !== mm) begin errors++; $display("FAIL sat_mm i=%0d got=%b exp=%b", i, mismatch_o, mm); end
      end
      checks++; if (err_cnt_o !== 8'd255 || 8'(m_err) !== 8'd255) begin errors++; $display("FAIL sat_err got=%0d exp=255", err_cnt_o); end
      checks++; if (tot_out_o !== 8'd24) begin errors++; $display("FAIL sat_tout got=%0d exp=24", tot_out_o); end
      checks++; if (cur_ch_o !== 2'(m_cur)) begin errors++; $display("FAIL sat_cur got=%0d exp=%0d", cur_ch_o, m_cur); end
   endtask

   task automatic test_reset_midline();
      logic [127:0] id;
      do_start(1);
      id = '0; id[63:32] = wd(1, 0);
      cycle(4'b0010, id, 1'b0, '0);
      cycle(4'b0010, id, 1'b1, wd(1, 0));
      do_reset();
      checks++; if (err_cnt_o !== 8'd0 || tot_in_o !== 8'd0 || tot_out_o !== 8'd0) begin errors++; $display("FAIL rml_cnt err=%0d tin=%0d tout=%0d exp=0/0/0", err_cnt_o, tot_in_o, tot_out_o); end
      checks++; if (cur_ch_o !== 2'd0 || done_o !== 1'b0) begin errors++; $display("FAIL rml_state cur=%0d done=%b exp=0/0", cur_ch_o, done_o); end
      do_end();
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rml_idle_end got=%b exp=0", done_o); end
      run_lines(3, -1, 0);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_corrupt();
      test_long_even();
      test_underflow();
      test_overflow();
      test_full_push_pop();
      test_saturate();
      test_reset_midline();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
